// File: rtl/stereo_sync_pkg.sv
// stereo_sync_pkg: shared types and constants for the stereo pair synchroniser.
//   state_t    - alignment FSM states (HUNT on reset, LOCK once both streams sit at start-of-frame)
//   beat_t     - side-FIFO entry layout {tuser, tlast, tdata} at the default beat width
//   FIFO_PTR_W - pointer width of the default-depth side FIFO
//   ptr_width  - pointer width for an arbitrary power-of-two FIFO depth
package stereo_sync_pkg;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int unsigned DEF_BPP        = 8;
  localparam int unsigned DEF_NPPC       = 4;
  localparam int unsigned DEF_TDATA_W    = DEF_BPP * DEF_NPPC;
  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam int unsigned FIFO_PTR_W     = $clog2(DEF_FIFO_DEPTH);

  typedef struct packed {
    logic                   tuser;
    logic                   tlast;
    logic [DEF_TDATA_W-1:0] tdata;
  } beat_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/stereo_sync_fifo.sv
// stereo_sync_fifo: first-word-fall-through FIFO with registered full/empty flags.
//   clk, rst  - clock, asynchronous active-high reset (flushes contents)
//   in_valid  - write request; the write happens when in_valid && in_ready
//   in_ready  - registered !full; held low during reset and for the first edge after it
//   in_data   - entry to store
//   out_valid - head is valid (registered !empty); a write becomes visible one cycle later
//   out_pop   - consume the head (ignored while empty)
//   out_data  - head entry
module stereo_sync_fifo
  import stereo_sync_pkg::*;
#(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_pop,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned     PTR_W    = ptr_width(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_next;
  logic             not_full_q, empty_q;
  logic             push, pop;

  assign push      = in_valid && not_full_q;
  assign pop       = out_pop && !empty_q;
  assign in_ready  = not_full_q;
  assign out_valid = !empty_q;
  assign out_data  = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + (PTR_W + 1)'(1);
    else if (!push && pop)
      count_next = count - (PTR_W + 1)'(1);
  end

  // not_full_q resets low so the upstream sees tready=0 until the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      not_full_q <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count      <= count_next;
      not_full_q <= (count_next != FULL_CNT);
      empty_q    <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/stereo_pair_sync.sv
// stereo_pair_sync: joins rectified left/right AXI4-Stream video into one beat stream.
//   aclk, areset      - clock, asynchronous active-high reset (flushes FIFOs, back to HUNT)
//   s_axis_l_*        - left input stream (tvalid/tready/tdata/tlast/tuser=start-of-frame)
//   s_axis_r_*        - right input stream, same signals
//   m_axis_*          - joined stream, tdata = {right, left}; tuser/tlast from the left head
//   locked            - high while both streams are aligned (FSM in LOCK)
//   sync_lost         - one-cycle pulse the cycle after an L/R tuser/tlast mismatch
// Optional macro STEREO_SYNC_STATS_EN adds frame_count[31:0] (accepted start-of-frame beats)
// and resync_count[15:0] (sync_lost pulses, saturating).
module stereo_pair_sync
  import stereo_sync_pkg::*;
#(
  parameter int unsigned BPP              = 8,
  parameter int unsigned NPPC             = 4,
  parameter int unsigned AXIS_TDATA_WIDTH = BPP * NPPC,
  parameter int unsigned FIFO_DEPTH       = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          s_axis_l_tvalid,
  output logic                          s_axis_l_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_l_tdata,
  input  logic                          s_axis_l_tlast,
  input  logic                          s_axis_l_tuser,
  input  logic                          s_axis_r_tvalid,
  output logic                          s_axis_r_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_r_tdata,
  input  logic                          s_axis_r_tlast,
  input  logic                          s_axis_r_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [2*AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  output logic                          locked,
  output logic                          sync_lost
`ifdef STEREO_SYNC_STATS_EN
  ,
  output logic [31:0]                   frame_count,
  output logic [15:0]                   resync_count
`endif
);

  typedef struct packed {
    logic                        tuser;
    logic                        tlast;
    logic [AXIS_TDATA_WIDTH-1:0] tdata;
  } side_beat_t;

  localparam int unsigned BEAT_W = $bits(side_beat_t);

  side_beat_t in_l, in_r, head_l, head_r;
  logic       hv_l, hv_r, pop_l, pop_r;
  logic       heads_match, m_valid, mismatch, sync_lost_q;
  state_t     state, state_d;

  assign in_l = '{tuser: s_axis_l_tuser, tlast: s_axis_l_tlast, tdata: s_axis_l_tdata};
  assign in_r = '{tuser: s_axis_r_tuser, tlast: s_axis_r_tlast, tdata: s_axis_r_tdata};

  stereo_sync_fifo #(.WIDTH(BEAT_W), .DEPTH(FIFO_DEPTH)) u_fifo_l (
    .clk      (aclk),
    .rst      (areset),
    .in_valid (s_axis_l_tvalid),
    .in_ready (s_axis_l_tready),
    .in_data  (in_l),
    .out_valid(hv_l),
    .out_pop  (pop_l),
    .out_data (head_l)
  );

  stereo_sync_fifo #(.WIDTH(BEAT_W), .DEPTH(FIFO_DEPTH)) u_fifo_r (
    .clk      (aclk),
    .rst      (areset),
    .in_valid (s_axis_r_tvalid),
    .in_ready (s_axis_r_tready),
    .in_data  (in_r),
    .out_valid(hv_r),
    .out_pop  (pop_r),
    .out_data (head_r)
  );

  assign heads_match = (head_l.tuser == head_r.tuser) && (head_l.tlast == head_r.tlast);

  // Heads only move on a pop, so an offered beat stays stable until accepted and
  // a mismatch can never appear while a beat is pending.
  always_comb begin
    state_d  = state;
    pop_l    = 1'b0;
    pop_r    = 1'b0;
    m_valid  = 1'b0;
    mismatch = 1'b0;
    case (state)
      HUNT: begin
        // Each side discards independently until it reaches a start-of-frame beat.
        pop_l = hv_l && !head_l.tuser;
        pop_r = hv_r && !head_r.tuser;
        if (hv_l && hv_r && head_l.tuser && head_r.tuser)
          state_d = LOCK;
      end
      LOCK: begin
        if (hv_l && hv_r) begin
          if (heads_match) begin
            m_valid = 1'b1;
            pop_l   = m_axis_tready;
            pop_r   = m_axis_tready;
          end else begin
            mismatch = 1'b1;
            state_d  = HUNT;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= HUNT;
      sync_lost_q <= 1'b0;
    end else begin
      state       <= state_d;
      sync_lost_q <= mismatch;
    end
  end

  assign m_axis_tvalid = m_valid;
  assign m_axis_tdata  = {head_r.tdata, head_l.tdata};
  assign m_axis_tlast  = head_l.tlast;
  assign m_axis_tuser  = head_l.tuser;
  assign locked        = (state == LOCK);
  assign sync_lost     = sync_lost_q;

`ifdef STEREO_SYNC_STATS_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      frame_count  <= '0;
      resync_count <= '0;
    end else begin
      if (m_valid && m_axis_tready && head_l.tuser)
        frame_count <= frame_count + 32'd1;
      if (sync_lost_q && (resync_count != '1))
        resync_count <= resync_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stereo_pair_sync.sv
// tb_stereo_pair_sync: directed bench for stereo_pair_sync with a transaction-level
// pairing model (per-side queues, frame hunting, tuser/tlast pairing rule).
module tb_stereo_pair_sync;

  localparam int W   = 32;
  localparam int BPL = 160;  // beats per line
  localparam int BPF = 640;  // beats per frame (4 lines)

  typedef struct {
    bit          gap;
    bit          user;
    bit          last;
    logic [W-1:0] data;
  } item_t;

  typedef struct {
    bit          user;
    bit          last;
    logic [W-1:0] data;
  } mbeat_t;

  logic           aclk = 1'b0;
  logic           areset;
  logic           s_axis_l_tvalid, s_axis_l_tready, s_axis_l_tlast, s_axis_l_tuser;
  logic [W-1:0]   s_axis_l_tdata;
  logic           s_axis_r_tvalid, s_axis_r_tready, s_axis_r_tlast, s_axis_r_tuser;
  logic [W-1:0]   s_axis_r_tdata;
  logic           m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic [2*W-1:0] m_axis_tdata;
  logic           locked, sync_lost;
`ifdef STEREO_SYNC_STATS_EN
  logic [31:0]    frame_count;
  logic [15:0]    resync_count;
`endif

  stereo_pair_sync #(
    .BPP(8), .NPPC(4), .AXIS_TDATA_WIDTH(W), .FIFO_DEPTH(16)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_l_tvalid(s_axis_l_tvalid), .s_axis_l_tready(s_axis_l_tready),
    .s_axis_l_tdata(s_axis_l_tdata), .s_axis_l_tlast(s_axis_l_tlast), .s_axis_l_tuser(s_axis_l_tuser),
    .s_axis_r_tvalid(s_axis_r_tvalid), .s_axis_r_tready(s_axis_r_tready),
    .s_axis_r_tdata(s_axis_r_tdata), .s_axis_r_tlast(s_axis_r_tlast), .s_axis_r_tuser(s_axis_r_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .locked(locked), .sync_lost(sync_lost)
`ifdef STEREO_SYNC_STATS_EN
    , .frame_count(frame_count), .resync_count(resync_count)
`endif
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus queues and model state
  item_t  ql[$], qr[$];
  mbeat_t mql[$], mqr[$];
  bit     m_locked = 0;
  int     exp_sl = 0;

  // per-cycle observations
  logic        hs_l, hs_r, hs_m;
  int          cyc = 0;
  int          in_l_cnt, out_cnt, sof_cnt, last_cnt;
  int          first_in_cyc, first_out_cyc;
  logic [65:0] first_out;
  bit          stall_pending = 0;
  logic [65:0] held;
  int          dut_sl = 0, sl_start;
  bit          unlocked_seen;
  int          snap_in_l;
  logic        snap_rdy_l, snap_rdy_r;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pix(input int side, input int frame, input int i);
    return {4'(side), 12'(frame), 16'(i)};
  endfunction

  // Resolve hunting and mismatches until a matched pair sits at both fronts (1),
  // or more input is needed to decide (0).
  function automatic bit model_advance();
    for (int k = 0; k < 100000; k++) begin
      if (!m_locked) begin
        while (mql.size() > 0 && !mql[0].user) void'(mql.pop_front());
        while (mqr.size() > 0 && !mqr[0].user) void'(mqr.pop_front());
        if (mql.size() > 0 && mqr.size() > 0) m_locked = 1;
        else return 0;
      end else begin
        if (mql.size() == 0 || mqr.size() == 0) return 0;
        if (mql[0].user == mqr[0].user && mql[0].last == mqr[0].last) return 1;
        exp_sl++;
        m_locked = 0;
      end
    end
    return 0;
  endfunction

  function automatic void model_flush();
    mql.delete();
    mqr.delete();
    m_locked = 0;
    stall_pending = 0;
  endfunction

  // One clock: observe and compare at the falling edge, return just after the rising edge.
  task automatic cycle();
    mbeat_t el, er;
    @(negedge aclk);
    cyc++;
    if (!areset) begin
      hs_l = s_axis_l_tvalid && s_axis_l_tready;
      hs_r = s_axis_r_tvalid && s_axis_r_tready;
      hs_m = m_axis_tvalid && m_axis_tready;
      if (stall_pending)
        check("stall_hold", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {1'b1, held});
      if (m_axis_tvalid) begin
        check("valid_only_when_locked", locked, 1);
        if (first_out_cyc < 0) begin
          first_out_cyc = cyc;
          first_out = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
        end
      end
      if (hs_m) begin
        if (model_advance()) begin
          el = mql.pop_front();
          er = mqr.pop_front();
          check("out_beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, {el.user, el.last, er.data, el.data});
        end else begin
          n_tests++;
          n_fail++;
          $display("FAIL out_beat: got 0x%0h, required no beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata});
        end
        out_cnt++;
        if (m_axis_tuser) sof_cnt++;
        if (m_axis_tlast) last_cnt++;
      end
      stall_pending = m_axis_tvalid && !m_axis_tready;
      held = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (sync_lost) dut_sl++;
      if (!locked) unlocked_seen = 1;
      if (hs_l) begin
        mql.push_back('{user: s_axis_l_tuser, last: s_axis_l_tlast, data: s_axis_l_tdata});
        if (first_in_cyc < 0) first_in_cyc = cyc;
        in_l_cnt++;
      end
      if (hs_r) mqr.push_back('{user: s_axis_r_tuser, last: s_axis_r_tlast, data: s_axis_r_tdata});
    end else begin
      hs_l = 0; hs_r = 0; hs_m = 0;
    end
    @(posedge aclk);
    #1;
  endtask

  function automatic logic ready_fn(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (c < 30) return 1'b0;
    if (((c - 30) % 60) < 20) return 1'b0;
    return 1'(c % 2);
  endfunction

  task automatic add_frame(input int side, input int frame, input int skip);
    item_t it;
    for (int i = 0; i < BPF; i++) begin
      if (i == skip) continue;
      it = '{gap: 0, user: (i == 0), last: ((i % BPL) == BPL - 1), data: pix(side, frame, i)};
      if (side == 0) ql.push_back(it); else qr.push_back(it);
    end
  endtask

  task automatic add_fill(input int side, input int n, input bit gap);
    item_t it;
    for (int i = 0; i < n; i++) begin
      it = '{gap: gap, user: 0, last: 0, data: 32'hDEAD_0000 + W'(i)};
      if (side == 0) ql.push_back(it); else qr.push_back(it);
    end
  endtask

  task automatic drive_side(input int side);
    item_t it;
    bit    have;
    have = (side == 0) ? (ql.size() > 0) : (qr.size() > 0);
    if (have) it = (side == 0) ? ql[0] : qr[0];
    else it = '{gap: 1, user: 0, last: 0, data: '0};
    if (side == 0) begin
      s_axis_l_tvalid = !it.gap; s_axis_l_tuser = it.user; s_axis_l_tlast = it.last; s_axis_l_tdata = it.data;
    end else begin
      s_axis_r_tvalid = !it.gap; s_axis_r_tuser = it.user; s_axis_r_tlast = it.last; s_axis_r_tdata = it.data;
    end
  endtask

  task automatic run(input int mode, input int stop_l, input int max_cycles);
    int c = 0;
    int idle = 0;
    while (1) begin
      drive_side(0);
      drive_side(1);
      m_axis_tready = ready_fn(mode, c);
      cycle();
      if (c == 25) begin
        snap_in_l = in_l_cnt; snap_rdy_l = s_axis_l_tready; snap_rdy_r = s_axis_r_tready;
      end
      if (ql.size() > 0 && (ql[0].gap || hs_l)) void'(ql.pop_front());
      if (qr.size() > 0 && (qr[0].gap || hs_r)) void'(qr.pop_front());
      c++;
      if (stop_l > 0 && in_l_cnt >= stop_l) return;
      if (ql.size() == 0 && qr.size() == 0 && !m_axis_tvalid) idle++; else idle = 0;
      if (idle >= 8) return;
      if (c >= max_cycles) begin
        n_tests++;
        n_fail++;
        $display("FAIL run_timeout: got %0d cycles, required completion", c);
        return;
      end
    end
  endtask

  task automatic test_begin();
    in_l_cnt = 0; out_cnt = 0; sof_cnt = 0; last_cnt = 0;
    first_in_cyc = -1; first_out_cyc = -1; first_out = '0;
    sl_start = dut_sl; unlocked_seen = 0;
  endtask

  task automatic test_end();
    bit pending;
    pending = model_advance();
    check("no_missing_output", pending, 0);
    check("sync_lost_total", dut_sl, exp_sl);
    check("locked_state", locked, m_locked);
  endtask

  initial begin
    areset = 1'b1;
    s_axis_l_tvalid = 0; s_axis_l_tuser = 0; s_axis_l_tlast = 0; s_axis_l_tdata = '0;
    s_axis_r_tvalid = 0; s_axis_r_tuser = 0; s_axis_r_tlast = 0; s_axis_r_tdata = '0;
    m_axis_tready = 0;
    repeat (3) @(posedge aclk);
    #1;

    // reset values
    check("rst_l_tready", s_axis_l_tready, 0);
    check("rst_r_tready", s_axis_r_tready, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_locked", locked, 0);
    check("rst_sync_lost", sync_lost, 0);
    areset = 1'b0;
    #1;
    check("release_tready_still_low", s_axis_l_tready, 0);
    @(posedge aclk);
    #1;
    check("first_clk_l_tready", s_axis_l_tready, 1);
    check("first_clk_r_tready", s_axis_r_tready, 1);

    // skewed start: L has 3 garbage beats, R starts 7 cycles late
    test_begin();
    add_fill(0, 3, 0);
    add_frame(0, 1, -1);
    add_fill(1, 7, 1);
    add_frame(1, 1, -1);
    run(0, 0, 3000);
    check("skew_beats", out_cnt, BPF);
    check("skew_sof_count", sof_cnt, 1);
    check("skew_first_beat", first_out, {1'b1, 1'b0, pix(1, 1, 0), pix(0, 1, 0)});
    check("skew_no_sync_lost", dut_sl - sl_start, 0);
    test_end();

    // aligned lockstep frames, FSM already in LOCK
    test_begin();
    add_frame(0, 2, -1); add_frame(0, 3, -1);
    add_frame(1, 2, -1); add_frame(1, 3, -1);
    run(0, 0, 4000);
    check("aligned_latency", first_out_cyc - first_in_cyc, 1);
    check("aligned_first_beat", first_out, {1'b1, 1'b0, pix(1, 2, 0), pix(0, 2, 0)});
    check("aligned_beats", out_cnt, 2 * BPF);
    check("aligned_tlast_count", last_cnt, 8);
    check("aligned_sof_count", sof_cnt, 2);
    check("aligned_locked", locked, 1);
    test_end();

    // backpressure: 30 low cycles first, then toggling with 20-cycle low bursts
    test_begin();
    add_frame(0, 4, -1);
    add_frame(1, 4, -1);
    run(1, 0, 8000);
    check("bp_buffered_beats", snap_in_l, 16);
    check("bp_l_tready_full", snap_rdy_l, 0);
    check("bp_r_tready_full", snap_rdy_r, 0);
    check("bp_beats", out_cnt, BPF);
    test_end();

    // mismatch: R drops beat 80 of line 2; L318 meets R's end-of-line
    test_begin();
    add_frame(0, 5, -1); add_frame(0, 6, -1);
    add_frame(1, 5, BPL + 80); add_frame(1, 6, -1);
    run(0, 0, 4000);
    check("mm_sync_lost_pulses", dut_sl - sl_start, 1);
    check("mm_locked_fell", unlocked_seen, 1);
    check("mm_beats", out_cnt, 318 + BPF);
    check("mm_sof_count", sof_cnt, 2);
    test_end();
`ifdef STEREO_SYNC_STATS_EN
    check("stats_frame_count", frame_count, 6);
    check("stats_resync_count", resync_count, 1);
`endif

    // reset mid-frame at input beat 300
    test_begin();
    add_frame(0, 7, -1);
    add_frame(1, 7, -1);
    run(0, 300, 2000);
    #2;
    areset = 1'b1;
    model_flush();
    #1;
    check("midrst_m_tvalid", m_axis_tvalid, 0);
    check("midrst_locked", locked, 0);
    check("midrst_l_tready", s_axis_l_tready, 0);
    check("midrst_r_tready", s_axis_r_tready, 0);
    ql.delete();
    qr.delete();
    s_axis_l_tvalid = 0;
    s_axis_r_tvalid = 0;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    test_begin();
    add_frame(0, 8, -1);
    add_frame(1, 8, -1);
    run(0, 0, 3000);
    check("postrst_beats", out_cnt, BPF);
    check("postrst_sof_count", sof_cnt, 1);
    check("postrst_tlast_count", last_cnt, 4);
    test_end();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
